// File: rtl/gba_video_pkg.sv
// rtl/gba_video_pkg.sv - shared GBA video timing constants and raster position type
package gba_video_pkg;
    localparam int GBA_H_ACTIVE = 240;
    localparam int GBA_V_ACTIVE = 160;
    localparam int GBA_H_TOTAL  = 308;
    localparam int GBA_V_TOTAL  = 228;
    localparam int GBA_H_W      = 9;
    localparam int GBA_V_W      = 8;

    typedef struct packed {
        logic [GBA_H_W-1:0] hcount;
        logic [GBA_V_W-1:0] vcount;
    } raster_pos_t;
endpackage

// File: rtl/gba_raster_driver_counter.sv
// rtl/gba_raster_driver_counter.sv - wrapping counter 0..MAX with enable and synchronous clear
module raster_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             last
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign last  = (count_q == MAX_V);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = last ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/gba_raster_driver.sv
// rtl/gba_raster_driver.sv - raster timing, status/irq strobes and framebuffer double-buffer select
module gba_raster_driver
    import gba_video_pkg::*;
#(
    parameter int H_ACTIVE  = GBA_H_ACTIVE,
    parameter int V_ACTIVE  = GBA_V_ACTIVE,
    parameter int H_TOTAL   = GBA_H_TOTAL,
    parameter int V_TOTAL   = GBA_V_TOTAL,
    parameter int CLK_DIV   = 4,
    parameter int H_W       = GBA_H_W,
    parameter int V_W       = GBA_V_W,
    parameter int ADDR_W    = 17,
    parameter int AUTO_SWAP = 0
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              en,
    input  logic [V_W-1:0]    lyc,
    input  logic              swap_req,
    output logic              step,
    output logic [H_W-1:0]    hcount,
    output logic [V_W-1:0]    vcount,
    output logic              wen,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              hblank,
    output logic              vblank,
    output logic              vmatch,
    output logic              hblank_irq,
    output logic              vblank_irq,
    output logic              vmatch_irq,
    output logic              frame_start,
    output logic              buf_sel,
    output logic              swap_pending,
    output logic              swap_done
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (H_TOTAL <= H_ACTIVE || V_TOTAL <= V_ACTIVE || CLK_DIV < 1 ||
        V_ACTIVE * H_ACTIVE > 2 ** ADDR_W ||
        H_TOTAL > 2 ** H_W || V_TOTAL > 2 ** V_W) begin : g_bad_params
        $error("gba_raster_driver: inconsistent timing or width parameters");
    end

    logic [DIV_W-1:0] div_cnt;
    logic             div_last, h_last, v_last, addr_last;
    logic             line_wrap, frame_wrap;
    logic [H_W-1:0]   h_next;
    logic [V_W-1:0]   v_next;
    logic             enter_vblank, do_swap;
    logic             unused_ok;

    logic hblank_irq_q, hblank_irq_d, vblank_irq_q, vblank_irq_d;
    logic vmatch_irq_q, vmatch_irq_d, frame_start_q, frame_start_d;
    logic buf_sel_q, buf_sel_d, swap_pending_q, swap_pending_d;
    logic swap_done_q, swap_done_d;

    assign step       = en && div_last;
    assign line_wrap  = step && h_last;
    assign frame_wrap = line_wrap && v_last;

    raster_counter #(.WIDTH(DIV_W), .MAX(CLK_DIV - 1)) u_div (
        .clk(clk), .rst_b(rst_b), .en(en), .clear(1'b0), .count(div_cnt), .last(div_last)
    );
    raster_counter #(.WIDTH(H_W), .MAX(H_TOTAL - 1)) u_hcount (
        .clk(clk), .rst_b(rst_b), .en(step), .clear(1'b0), .count(hcount), .last(h_last)
    );
    raster_counter #(.WIDTH(V_W), .MAX(V_TOTAL - 1)) u_vcount (
        .clk(clk), .rst_b(rst_b), .en(line_wrap), .clear(1'b0), .count(vcount), .last(v_last)
    );
    // Address only advances over visible pixels, so it parks at V_ACTIVE*H_ACTIVE through VBlank.
    raster_counter #(.WIDTH(ADDR_W), .MAX(2 ** ADDR_W - 1)) u_addr (
        .clk(clk), .rst_b(rst_b), .en(step && wen), .clear(frame_wrap),
        .count(wr_addr), .last(addr_last)
    );

    assign unused_ok = &{1'b0, div_cnt, addr_last};

    assign wen    = (hcount < H_W'(H_ACTIVE)) && (vcount < V_W'(V_ACTIVE));
    assign hblank = (hcount >= H_W'(H_ACTIVE));
    assign vblank = (vcount >= V_W'(V_ACTIVE));
    assign vmatch = (vcount == lyc);

    always_comb begin
        h_next         = h_last ? '0 : hcount + H_W'(1);
        v_next         = v_last ? '0 : vcount + V_W'(1);
        enter_vblank   = line_wrap && (v_next == V_W'(V_ACTIVE));
        do_swap        = enter_vblank && (swap_pending_q || swap_req || (AUTO_SWAP != 0));
        hblank_irq_d   = step && (h_next == H_W'(H_ACTIVE));
        vblank_irq_d   = enter_vblank;
        vmatch_irq_d   = line_wrap && (v_next == lyc);
        frame_start_d  = frame_wrap;
        swap_done_d    = do_swap;
        buf_sel_d      = buf_sel_q ^ do_swap;
        swap_pending_d = !do_swap && (swap_pending_q || swap_req);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hblank_irq_q   <= 1'b0;
            vblank_irq_q   <= 1'b0;
            vmatch_irq_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            buf_sel_q      <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
        end else begin
            hblank_irq_q   <= hblank_irq_d;
            vblank_irq_q   <= vblank_irq_d;
            vmatch_irq_q   <= vmatch_irq_d;
            frame_start_q  <= frame_start_d;
            buf_sel_q      <= buf_sel_d;
            swap_pending_q <= swap_pending_d;
            swap_done_q    <= swap_done_d;
        end
    end

    assign hblank_irq   = hblank_irq_q;
    assign vblank_irq   = vblank_irq_q;
    assign vmatch_irq   = vmatch_irq_q;
    assign frame_start  = frame_start_q;
    assign buf_sel      = buf_sel_q;
    assign swap_pending = swap_pending_q;
    assign swap_done    = swap_done_q;
endmodule

// File: tb/tb_gba_raster_driver.sv
// tb/tb_gba_raster_driver.sv - self-checking bench for gba_raster_driver
module tb_gba_raster_driver;
    import gba_video_pkg::*;

    localparam int SH_A = 4, SH_T = 6, SV_A = 3, SV_T = 5;
    localparam int FRAME = SH_T * SV_T;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Instance A: default GBA timing
    logic        a_rst_b = 1'b0, a_en = 1'b1, a_req = 1'b0;
    logic [7:0]  a_lyc = 8'd0;
    logic        a_step, a_wen, a_hbl, a_vbl, a_vm, a_hirq, a_virq, a_vmirq, a_fs, a_buf, a_pend, a_sd;
    logic [8:0]  a_h;
    logic [7:0]  a_v;
    logic [16:0] a_addr;

    gba_raster_driver u_a (
        .clk(clk), .rst_b(a_rst_b), .en(a_en), .lyc(a_lyc), .swap_req(a_req),
        .step(a_step), .hcount(a_h), .vcount(a_v), .wen(a_wen), .wr_addr(a_addr),
        .hblank(a_hbl), .vblank(a_vbl), .vmatch(a_vm), .hblank_irq(a_hirq),
        .vblank_irq(a_virq), .vmatch_irq(a_vmirq), .frame_start(a_fs),
        .buf_sel(a_buf), .swap_pending(a_pend), .swap_done(a_sd)
    );

    // Instance B: small timing, manual swap, randomized against the model
    logic        b_rst_b = 1'b0, b_en = 1'b0, b_req = 1'b0;
    logic [2:0]  b_lyc = 3'd0;
    logic        b_step, b_wen, b_hbl, b_vbl, b_vm, b_hirq, b_virq, b_vmirq, b_fs, b_buf, b_pend, b_sd;
    logic [2:0]  b_h, b_v;
    logic [3:0]  b_addr;

    gba_raster_driver #(.H_ACTIVE(SH_A), .V_ACTIVE(SV_A), .H_TOTAL(SH_T), .V_TOTAL(SV_T),
                        .CLK_DIV(1), .H_W(3), .V_W(3), .ADDR_W(4), .AUTO_SWAP(0)) u_b (
        .clk(clk), .rst_b(b_rst_b), .en(b_en), .lyc(b_lyc), .swap_req(b_req),
        .step(b_step), .hcount(b_h), .vcount(b_v), .wen(b_wen), .wr_addr(b_addr),
        .hblank(b_hbl), .vblank(b_vbl), .vmatch(b_vm), .hblank_irq(b_hirq),
        .vblank_irq(b_virq), .vmatch_irq(b_vmirq), .frame_start(b_fs),
        .buf_sel(b_buf), .swap_pending(b_pend), .swap_done(b_sd)
    );

    // Instance C: small timing with automatic swap every frame
    logic        c_rst_b = 1'b0, c_en = 1'b1, c_req = 1'b0;
    logic [2:0]  c_lyc = 3'd7;
    logic        c_step, c_wen, c_hbl, c_vbl, c_vm, c_hirq, c_virq, c_vmirq, c_fs, c_buf, c_pend, c_sd;
    logic [2:0]  c_h, c_v;
    logic [3:0]  c_addr;

    gba_raster_driver #(.H_ACTIVE(SH_A), .V_ACTIVE(SV_A), .H_TOTAL(SH_T), .V_TOTAL(SV_T),
                        .CLK_DIV(1), .H_W(3), .V_W(3), .ADDR_W(4), .AUTO_SWAP(1)) u_c (
        .clk(clk), .rst_b(c_rst_b), .en(c_en), .lyc(c_lyc), .swap_req(c_req),
        .step(c_step), .hcount(c_h), .vcount(c_v), .wen(c_wen), .wr_addr(c_addr),
        .hblank(c_hbl), .vblank(c_vbl), .vmatch(c_vm), .hblank_irq(c_hirq),
        .vblank_irq(c_virq), .vmatch_irq(c_vmirq), .frame_start(c_fs),
        .buf_sel(c_buf), .swap_pending(c_pend), .swap_done(c_sd)
    );

    int a_hirq_cnt = 0, a_virq_cnt = 0;
    always @(negedge clk) begin
        if (a_rst_b) begin
            a_hirq_cnt += int'(a_hirq);
            a_virq_cnt += int'(a_virq);
        end
    end

    // Reference model for B: position is a step index within the frame
    int   m_n;
    logic m_pend, m_buf, m_hirq, m_virq, m_vmirq, m_fs, m_sd;

    function automatic int addr_of(input int n);
        int v = n / SH_T;
        int h = n % SH_T;
        if (v >= SV_A) return SV_A * SH_A;
        if (h < SH_A) return v * SH_A + h;
        return (v + 1) * SH_A;
    endfunction

    task automatic model_reset();
        m_n = 0; m_pend = 0; m_buf = 0;
        m_hirq = 0; m_virq = 0; m_vmirq = 0; m_fs = 0; m_sd = 0;
    endtask

    task automatic model_step();
        m_hirq = 0; m_virq = 0; m_vmirq = 0; m_fs = 0; m_sd = 0;
        if (b_en) begin
            m_n     = (m_n + 1) % FRAME;
            m_hirq  = (m_n % SH_T) == SH_A;
            m_virq  = m_n == SV_A * SH_T;
            m_fs    = m_n == 0;
            m_vmirq = ((m_n % SH_T) == 0) && ((m_n / SH_T) == int'(b_lyc));
        end
        if (m_virq && (m_pend || b_req)) begin
            m_buf = !m_buf; m_pend = 0; m_sd = 1;
        end else begin
            m_pend = m_pend || b_req;
        end
    endtask

    task automatic b_check(input logic en_i);
        int h = m_n % SH_T;
        int v = m_n / SH_T;
        chk("b_step", 32'(b_step), 32'(en_i));
        chk("b_hcount", 32'(b_h), h);
        chk("b_vcount", 32'(b_v), v);
        chk("b_wr_addr", 32'(b_addr), addr_of(m_n));
        chk("b_wen", 32'(b_wen), 32'(h < SH_A && v < SV_A));
        chk("b_hblank", 32'(b_hbl), 32'(h >= SH_A));
        chk("b_vblank", 32'(b_vbl), 32'(v >= SV_A));
        chk("b_vmatch", 32'(b_vm), 32'(v == int'(b_lyc)));
        chk("b_hblank_irq", 32'(b_hirq), 32'(m_hirq));
        chk("b_vblank_irq", 32'(b_virq), 32'(m_virq));
        chk("b_vmatch_irq", 32'(b_vmirq), 32'(m_vmirq));
        chk("b_frame_start", 32'(b_fs), 32'(m_fs));
        chk("b_swap_done", 32'(b_sd), 32'(m_sd));
        chk("b_buf_sel", 32'(b_buf), 32'(m_buf));
        chk("b_swap_pending", 32'(b_pend), 32'(m_pend));
    endtask

    task automatic b_cycle(input logic en_i, input logic req_i);
        b_en = en_i; b_req = req_i;
        #1;
        b_check(en_i);
        model_step();
        @(negedge clk);
    endtask

    task automatic b_run(input int k, input logic en_i, input logic req_i);
        for (int i = 0; i < k; i++) b_cycle(en_i, req_i);
    endtask

    task automatic b_reset();
        b_rst_b = 1'b0; b_req = 1'b0;
        model_reset();
        #1;
        chk("b_rst_hcount", 32'(b_h), 0);
        chk("b_rst_wr_addr", 32'(b_addr), 0);
        chk("b_rst_swap_pending", 32'(b_pend), 0);
        chk("b_rst_buf_sel", 32'(b_buf), 0);
        @(negedge clk);
        b_rst_b = 1'b1;
    endtask

    typedef struct {
        int          cyc;
        raster_pos_t pos;
        logic [16:0] addr;
        logic        wen, hbl, hirq, stp;
    } a_vec_t;

    typedef struct {
        int   cyc;
        logic bsel, sd;
    } c_vec_t;

    function automatic a_vec_t mk_a(input int cyc, input int h, input int v, input int addr,
                                    input logic wen, input logic hbl, input logic hirq, input logic stp);
        a_vec_t r;
        r.cyc = cyc; r.pos.hcount = 9'(h); r.pos.vcount = 8'(v); r.addr = 17'(addr);
        r.wen = wen; r.hbl = hbl; r.hirq = hirq; r.stp = stp;
        return r;
    endfunction

    initial begin
        a_vec_t av[9];
        c_vec_t cv[6];
        int     cur;

        av[0] = mk_a(0,    0,   0, 0,   1, 0, 0, 0);
        av[1] = mk_a(3,    0,   0, 0,   1, 0, 0, 1);
        av[2] = mk_a(4,    1,   0, 1,   1, 0, 0, 0);
        av[3] = mk_a(959,  239, 0, 239, 1, 0, 0, 1);
        av[4] = mk_a(960,  240, 0, 240, 0, 1, 1, 0);
        av[5] = mk_a(961,  240, 0, 240, 0, 1, 0, 0);
        av[6] = mk_a(1231, 307, 0, 240, 0, 1, 0, 1);
        av[7] = mk_a(1232, 0,   1, 240, 1, 0, 0, 0);
        av[8] = mk_a(1236, 1,   1, 241, 1, 0, 0, 0);

        cv[0] = '{17, 1'b0, 1'b0};
        cv[1] = '{18, 1'b1, 1'b1};
        cv[2] = '{19, 1'b1, 1'b0};
        cv[3] = '{47, 1'b1, 1'b0};
        cv[4] = '{48, 1'b0, 1'b1};
        cv[5] = '{78, 1'b1, 1'b1};

        // Default timing: reset state then table of positions
        @(negedge clk);
        #1;
        chk("a_rst_vmatch", 32'(a_vm), 1);
        chk("a_rst_misc", 32'({a_step, a_hbl, a_vbl, a_hirq, a_virq, a_vmirq, a_fs, a_buf, a_pend, a_sd}), 0);
        chk("a_rst_wen", 32'(a_wen), 1);
        @(negedge clk);
        a_rst_b = 1'b1;
        cur = 0;
        foreach (av[i]) begin
            for (int k = cur; k < av[i].cyc; k++) @(posedge clk);
            if (av[i].cyc != cur) @(negedge clk);
            cur = av[i].cyc;
            chk($sformatf("a_pos@%0d", cur), 32'({a_h, a_v}), 32'(av[i].pos));
            chk($sformatf("a_wr_addr@%0d", cur), 32'(a_addr), 32'(av[i].addr));
            chk($sformatf("a_wen@%0d", cur), 32'(a_wen), 32'(av[i].wen));
            chk($sformatf("a_hblank@%0d", cur), 32'(a_hbl), 32'(av[i].hbl));
            chk($sformatf("a_hblank_irq@%0d", cur), 32'(a_hirq), 32'(av[i].hirq));
            chk($sformatf("a_step@%0d", cur), 32'(a_step), 32'(av[i].stp));
        end
        chk("a_hirq_count", a_hirq_cnt, 1);
        chk("a_virq_count", a_virq_cnt, 0);
        chk("a_vblank_line1", 32'(a_vbl), 0);

        // Small timing: lyc strobe, frame length, hold, swap handshake corners
        b_lyc = 3'd2;
        b_reset();
        b_run(12, 1, 0);
        chk("b_lyc_irq_at_line2", 32'({b_vmirq, b_vm, b_v, b_h}), 32'({1'b1, 1'b1, 3'd2, 3'd0}));
        b_run(2, 1, 0);
        b_lyc = 3'd0;
        #1 chk("b_lyc_rewrite_level_lo", 32'(b_vm), 0);
        b_lyc = 3'd2;
        #1 chk("b_lyc_rewrite_level_hi", 32'(b_vm), 1);
        b_run(1, 1, 0);
        chk("b_lyc_rewrite_no_irq", 32'(b_vmirq), 0);
        b_run(14, 1, 0);
        chk("b_frame_not_yet", 32'(b_fs), 0);
        b_run(1, 1, 0);
        chk("b_frame_len_30", 32'({b_fs, b_h, b_v, b_addr}), 32'({1'b1, 3'd0, 3'd0, 4'd0}));
        b_run(3, 1, 0);
        b_run(5, 0, 0);
        chk("b_hold_hcount", 32'({b_h, b_addr}), 32'({3'd3, 4'd3}));
        b_run(1, 1, 1);
        chk("b_req_pending", 32'(b_pend), 1);
        b_run(3, 1, 1);
        b_run(11, 1, 0);
        chk("b_swap_at_vblank", 32'({b_buf, b_sd, b_virq, b_vbl, b_pend}), 32'(5'b11110));
        b_run(1, 1, 1);
        chk("b_late_req_waits", 32'({b_buf, b_pend}), 32'(2'b11));
        b_run(29, 1, 0);
        chk("b_late_req_next_frame", 32'({b_buf, b_sd}), 32'(2'b01));
        b_run(29, 1, 0);
        b_run(1, 1, 1);
        chk("b_coincident_req", 32'({b_buf, b_sd, b_pend}), 32'(3'b110));
        b_run(1, 1, 1);
        b_reset();
        b_run(18, 1, 0);
        chk("b_reset_drops_pending", 32'({b_buf, b_sd, b_virq}), 32'(3'b001));

        // Randomized en/swap_req/lyc with occasional mid-frame reset
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                b_reset();
            end else begin
                if ($urandom_range(0, 19) == 0) b_lyc = 3'($urandom_range(0, 5));
                b_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
            end
        end

        // Automatic swap every frame without requests
        c_rst_b = 1'b1;
        cur = 0;
        foreach (cv[i]) begin
            for (int k = cur; k < cv[i].cyc; k++) @(posedge clk);
            @(negedge clk);
            cur = cv[i].cyc;
            chk($sformatf("c_buf_sel@%0d", cur), 32'(c_buf), 32'(cv[i].bsel));
            chk($sformatf("c_swap_done@%0d", cur), 32'(c_sd), 32'(cv[i].sd));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gba_raster_driver.md
Name: gba_raster_driver

Overview:
- Parametrised raster timing and double-buffer controller for the graphics system.
- Generates the pixel step strobe, the horizontal and vertical position counters, active-area write enable and linear framebuffer write address.
- Generates HBlank, VBlank and VCOUNT-match status and interrupt strobes, plus a frame-synchronous front/back buffer select with a swap request handshake.
- Sits between graphics_top (the pixel producer) and the two framebuffer RAMs; also feeds DISPSTAT/VCOUNT to MMIO.

Parameters:
- H_ACTIVE, 240, visible pixels per line
- V_ACTIVE, 160, visible lines per frame
- H_TOTAL, 308, pixel slots per line including HBlank
- V_TOTAL, 228, lines per frame including VBlank
- CLK_DIV, 4, clk cycles per pixel step (>=1)
- H_W, 9, hcount width
- V_W, 8, vcount width
- ADDR_W, 17, wr_addr width
- AUTO_SWAP, 0, 1 = swap buffers every frame regardless of request

Ports:
- clk  in  1  pixel/graphics clock
- rst_b  in  1  reset
- en  in  1  run enable; low freezes all state
- lyc  in  V_W  VCOUNT compare value (DISPSTAT[15:8])
- swap_req  in  1  one-cycle request to swap at next VBlank entry
- step  out  1  pixel strobe
- hcount  out  H_W  current pixel slot
- vcount  out  V_W  current line
- wen  out  1  framebuffer write enable
- wr_addr  out  ADDR_W  linear write address
- hblank  out  1  status level
- vblank  out  1  status level
- vmatch  out  1  status level
- hblank_irq  out  1  one-cycle strobe
- vblank_irq  out  1  one-cycle strobe
- vmatch_irq  out  1  one-cycle strobe
- frame_start  out  1  one-cycle strobe
- buf_sel  out  1  back (write) buffer index; front = ~buf_sel
- swap_pending  out  1  request latched, not yet serviced
- swap_done  out  1  one-cycle strobe

Behaviour:
- Reset: rst_b asynchronous, active-low; clock clk.
  - All counters, wr_addr, buf_sel, swap_pending and strobes are 0.
  - Consequently wen = 1 and vmatch = (lyc == 0) out of reset.
- Divider:
  - div counts 0..CLK_DIV-1 while en.
  - step = en && div == CLK_DIV-1 (combinational).
  - With CLK_DIV = 1, step = en.
- Counters advance only on step:
  - hcount wraps from H_TOTAL-1 to 0.
  - On that wrap, vcount increments, wrapping from V_TOTAL-1 to 0.
- Levels (combinational from counters):
  - wen = hcount < H_ACTIVE && vcount < V_ACTIVE
  - hblank = hcount >= H_ACTIVE
  - vblank = vcount >= V_ACTIVE
  - vmatch = vcount == lyc
- wr_addr:
  - Increments on step when wen.
  - Clears to 0 on the step that wraps the frame.
  - Invariant in the active area: wr_addr == vcount*H_ACTIVE + hcount. The address does not advance during blanking.
- Strobes:
  - Registered; high for exactly one clk in the first cycle the counters show the new position.
  - hblank_irq: entry to hcount == H_ACTIVE, on every line including VBlank lines.
  - vblank_irq: entry to (vcount, hcount) == (V_ACTIVE, 0).
  - frame_start: entry to (0, 0).
  - vmatch_irq: entry to hcount == 0 with new vcount == lyc.
  - A change of lyc mid-line affects the vmatch level only; it produces no strobe.
- Swap handshake:
  - swap_req sets swap_pending on the next clk edge.
  - On the step that enters VBlank: if swap_pending || swap_req || AUTO_SWAP, then buf_sel toggles, swap_pending clears and swap_done strobes with vblank_irq.
  - Extra requests while pending are absorbed; one swap per frame maximum.
  - A swap_req arriving after VBlank entry waits for the next frame.
- en low:
  - div, counters, wr_addr and buf_sel hold; strobes are 0.
  - swap_req is still latched.
  - When en returns, timing resumes from the held div value.
- Reset mid-frame: all state returns to reset values immediately; a pending swap is dropped.
- Elaboration check: H_TOTAL > H_ACTIVE, V_TOTAL > V_ACTIVE, V_ACTIVE*H_ACTIVE <= 2^ADDR_W, and counter widths fit.

Decomposition:
- Shared package gba_video_pkg:
  - Default timing constants GBA_H_ACTIVE, GBA_V_ACTIVE, GBA_H_TOTAL and GBA_V_TOTAL.
  - typedef raster_pos_t {hcount, vcount}.
- One sub-module: raster_counter #(WIDTH, MAX) with en/clear/last. It is instantiated for div, hcount and vcount; wr_addr uses it with clear on frame wrap.

Test Plan:
- Reset with lyc = 0 -> all outputs 0 except wen = 1 and vmatch = 1; after 4 clk, hcount = 1, wr_addr = 1.
- Defaults, run 4*308 clk -> vcount = 1, hcount = 0, wr_addr = 240, no vblank_irq; hblank_irq fires once at clk 960 (hcount = 240).
- Run 4*308*160 clk -> vblank_irq and vblank = 1, wr_addr = 38400 held; after 280896 clk -> frame_start, counters and wr_addr = 0.
- swap_req at line 10 -> swap_pending = 1 until VBlank entry, then buf_sel = 1 and swap_done with vblank_irq. A second request in the same frame causes no extra toggle. A request coincident with the entry step swaps at that entry.
- lyc = 100 -> vmatch_irq exactly at (100, 0); rewriting lyc = 100 mid-line 100 -> level only, no strobe. AUTO_SWAP = 1 -> buf_sel toggles every frame without requests.
- Small configuration H_ACTIVE = 4, H_TOTAL = 6, V_ACTIVE = 3, V_TOTAL = 5, CLK_DIV = 1; en toggled randomly; rst_b asserted mid-frame -> counters hold while en = 0, frame length 30 steps, immediate clear on reset, and a pending swap is dropped.
